// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding,
// slice width and default operand width.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB       = 4;
    localparam int N_DEFAULT = 12;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle of the nibble-serial adder.
// Handshake: a transfer happens on a rising CK edge where VALID and READY are both 1;
// the producer holds its payload stable while VALID=1 and READY=0.
interface nibble_serial_adder_if
    import nibble_serial_adder_pkg::*;
#(
    parameter int N = N_DEFAULT
) ();

    logic         IN_VALID;
    logic         IN_READY;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CI;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [N-1:0] SUM;
    logic         CO;

    modport slave (
        input  IN_VALID, A, B, CI, OUT_READY,
        output IN_READY, OUT_VALID, SUM, CO
    );

    modport master (
        output IN_VALID, A, B, CI, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, CO
    );

endinterface

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder: SUM = A + B + ci, carry-out on co.
module ripple_adder (
    output logic       co,
    output logic [3:0] SUM,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       ci
);

    logic c;

    always_comb begin
        c   = ci;
        SUM = '0;
        for (int i = 0; i < 4; i++) begin
            SUM[i] = A[i] ^ B[i] ^ c;
            c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit slice per cycle through a single ripple_adder,
// result held in DONE until the consumer takes it.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int NIB = nibble_serial_adder_pkg::NIB
) (
    input  logic                        CK,
    input  logic                        RN,
    nibble_serial_adder_if.slave        bus,
    output state_t                      dbg_state
);

    localparam int NSL = N / NIB;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           co_q, co_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   sum_q, sum_d;

    logic [NIB-1:0] a_sl, b_sl, add_sum;
    logic           add_co;
    logic           last;

    // Slice select: mux indexed by the slice counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSL; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*NIB +: NIB];
                b_sl = b_q[i*NIB +: NIB];
            end
        end
    end

    ripple_adder u_add (
        .co  (add_co),
        .SUM (add_sum),
        .A   (a_sl),
        .B   (b_sl),
        .ci  (carry_q)
    );

    assign last = (cnt_q == CW'(NSL - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = bus.CI;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Only the current slice is written; the others keep their old value.
                for (int i = 0; i < NSL; i++) begin
                    if (cnt_q == CW'(i)) sum_d[i*NIB +: NIB] = add_sum;
                end
                carry_d = add_co;
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    co_d    = add_co;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.SUM       = sum_q;
    assign bus.CO        = co_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized checks of the nibble-serial adder at N=12.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    logic   CK;
    logic   RN;
    state_t dbg_state;
    int     checks;
    int     failures;
    logic [12:0] exp_q[$];

    nibble_serial_adder_if #(.N(12)) bus ();

    nibble_serial_adder #(.N(12), .NIB(4)) dut (
        .CK        (CK),
        .RN        (RN),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic ci);
        int n;
        n = 0;
        bus.A        = a;
        bus.B        = b;
        bus.CI       = ci;
        bus.IN_VALID = 1'b1;
        while (bus.IN_READY !== 1'b1 && n < 20) begin
            @(posedge CK); #1;
            n++;
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: got %b expected 1", bus.IN_READY);
        end
        @(posedge CK); #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.OUT_VALID !== 1'b1 && lat < 20) begin
            @(posedge CK); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        bus.OUT_READY = 1'b1;
        @(posedge CK); #1;
        bus.OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        bus.A = '0; bus.B = '0; bus.CI = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        checks += 5;
        if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", bus.IN_READY); end
        if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", bus.OUT_VALID); end
        if (bus.SUM !== 12'h000) begin failures++; $display("FAIL rst_sum: got %h expected 000", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL rst_co: got %b expected 0", bus.CO); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d expected IDLE", dbg_state); end
        @(negedge CK);
        RN = 1'b1;
    endtask

    task automatic test_overflow();
        int lat;
        send(12'hFFF, 12'h001, 1'b0);
        checks++;
        if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL ovf_busy_ready: got %b expected 0", bus.IN_READY); end
        wait_valid(lat);
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL ovf_latency: got %0d expected 3", lat); end
        if (bus.SUM !== 12'h000) begin failures++; $display("FAIL ovf_sum: got %h expected 000", bus.SUM); end
        if (bus.CO !== 1'b1) begin failures++; $display("FAIL ovf_co: got %b expected 1", bus.CO); end
        handshake();
        checks += 2;
        if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL ovf_hs_valid: got %b expected 0", bus.OUT_VALID); end
        if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL ovf_hs_ready: got %b expected 1", bus.IN_READY); end
    endtask

    task automatic test_basic();
        int lat;
        send(12'h123, 12'h456, 1'b1);
        wait_valid(lat);
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        if (bus.SUM !== 12'h57A) begin failures++; $display("FAIL basic_sum: got %h expected 57a", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL basic_co: got %b expected 0", bus.CO); end
        handshake();
    endtask

    task automatic test_stall();
        int lat;
        send(12'hABC, 12'hDEF, 1'b1);
        wait_valid(lat);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL stall_latency: got %0d expected 3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge CK); #1;
            checks += 4;
            if (bus.OUT_VALID !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.OUT_VALID); end
            if (bus.SUM !== 12'h8AC) begin failures++; $display("FAIL stall_sum[%0d]: got %h expected 8ac", i, bus.SUM); end
            if (bus.CO !== 1'b1) begin failures++; $display("FAIL stall_co[%0d]: got %b expected 1", i, bus.CO); end
            if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, bus.IN_READY); end
        end
        handshake();
        checks += 2;
        if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b expected 1", bus.IN_READY); end
        if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL stall_release_valid: got %b expected 0", bus.OUT_VALID); end
    endtask

    task automatic test_back_to_back();
        int lat;
        send(12'h111, 12'h222, 1'b0);
        bus.IN_VALID = 1'b1;
        lat = 0;
        while (bus.OUT_VALID !== 1'b1 && lat < 20) begin
            bus.A  = 12'($urandom_range(0, 4095));
            bus.B  = 12'($urandom_range(0, 4095));
            bus.CI = 1'($urandom_range(0, 1));
            @(posedge CK); #1;
            lat++;
        end
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL b2b_latency: got %0d expected 3", lat); end
        if (bus.SUM !== 12'h333) begin failures++; $display("FAIL b2b_sum: got %h expected 333", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL b2b_co: got %b expected 0", bus.CO); end
        bus.A = 12'h00F; bus.B = 12'h001; bus.CI = 1'b0;
        bus.OUT_READY = 1'b1;
        @(posedge CK); #1;
        bus.OUT_READY = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL b2b_no_same_cycle: got %b expected 1", bus.IN_READY); end
        @(posedge CK); #1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b0) begin failures++; $display("FAIL b2b_next_accept: got %b expected 0", bus.IN_READY); end
        wait_valid(lat);
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL b2b2_latency: got %0d expected 3", lat); end
        if (bus.SUM !== 12'h010) begin failures++; $display("FAIL b2b2_sum: got %h expected 010", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL b2b2_co: got %b expected 0", bus.CO); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        send(12'h555, 12'h555, 1'b0);
        @(posedge CK); #1;
        RN = 1'b0;
        #1;
        checks += 5;
        if (bus.IN_READY !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b expected 1", bus.IN_READY); end
        if (bus.OUT_VALID !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", bus.OUT_VALID); end
        if (bus.SUM !== 12'h000) begin failures++; $display("FAIL mid_rst_sum: got %h expected 000", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL mid_rst_co: got %b expected 0", bus.CO); end
        if (dbg_state !== IDLE) begin failures++; $display("FAIL mid_rst_state: got %0d expected IDLE", dbg_state); end
        @(negedge CK);
        RN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CK); #1;
            if (bus.OUT_VALID !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_no_valid: got %b expected 0", seen); end
        send(12'h7FF, 12'h001, 1'b0);
        wait_valid(lat);
        checks += 3;
        if (lat != 3) begin failures++; $display("FAIL post_rst_latency: got %0d expected 3", lat); end
        if (bus.SUM !== 12'h800) begin failures++; $display("FAIL post_rst_sum: got %h expected 800", bus.SUM); end
        if (bus.CO !== 1'b0) begin failures++; $display("FAIL post_rst_co: got %b expected 0", bus.CO); end
        handshake();
    endtask

    task automatic test_random();
        int lat;
        logic [11:0] a, b;
        logic        ci;
        logic [12:0] exp_v, got;
        for (int k = 0; k < 3000; k++) begin
            a  = 12'($urandom_range(0, 4095));
            b  = 12'($urandom_range(0, 4095));
            ci = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, a} + {1'b0, b} + {12'b0, ci});
            send(a, b, ci);
            wait_valid(lat);
            checks++;
            if (lat != 3) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 3", k, lat); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge CK); #1;
            end
            got   = {bus.CO, bus.SUM};
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL rand_sum[%0d]: got %h expected %h (a=%h b=%h ci=%b)", k, got, exp_v, a, b, ci);
            end
            handshake();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_overflow();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
